// File: rtl/aes_cipher_ctrl_if.sv
// Handshake and control bundle between the top-level AES control FSM (master)
// and the cipher round-sequencing controller (slave / responder).
interface aes_cipher_ctrl_if;
    // Request handshake and qualifiers
    logic       in_valid_i;
    logic       in_ready_o;
    logic       start_i;
    logic       dec_key_gen_i;
    logic       key_clear_i;
    logic       data_out_clear_i;
    logic       op_i;
    logic [2:0] key_len_i;

    // Completion handshake
    logic       out_valid_o;
    logic       out_ready_i;

    // Latched request state
    logic       dec_key_gen_o;
    logic       key_clear_o;
    logic       data_out_clear_o;
    logic       op_o;
    logic [2:0] key_len_o;
    logic [3:0] round_o;

    // Datapath register control
    logic [1:0] state_sel_o;
    logic       state_we_o;
    logic [1:0] add_rk_sel_o;
    logic [1:0] key_full_sel_o;
    logic       key_full_we_o;
    logic       key_dec_sel_o;
    logic       key_dec_we_o;
    logic       key_expand_step_o;
    logic       key_expand_clear_o;

    modport slave (
        input  in_valid_i, out_ready_i, start_i, dec_key_gen_i, key_clear_i,
               data_out_clear_i, op_i, key_len_i,
        output in_ready_o, out_valid_o, dec_key_gen_o, key_clear_o, data_out_clear_o,
               op_o, key_len_o, round_o, state_sel_o, state_we_o, add_rk_sel_o,
               key_full_sel_o, key_full_we_o, key_dec_sel_o, key_dec_we_o,
               key_expand_step_o, key_expand_clear_o
    );

    modport master (
        output in_valid_i, out_ready_i, start_i, dec_key_gen_i, key_clear_i,
               data_out_clear_i, op_i, key_len_i,
        input  in_ready_o, out_valid_o, dec_key_gen_o, key_clear_o, data_out_clear_o,
               op_o, key_len_o, round_o, state_sel_o, state_we_o, add_rk_sel_o,
               key_full_sel_o, key_full_we_o, key_dec_sel_o, key_dec_we_o,
               key_expand_step_o, key_expand_clear_o
    );
endinterface

// File: rtl/aes_cipher_ctrl.sv
// AES cipher round-sequencing controller: accepts start / key-gen / clear
// requests, walks INIT -> ROUND x (Nr-1) -> FINISH, and drives the selects and
// write enables of the state, full-key and decryption-key registers.
module aes_cipher_ctrl (
    input  logic             clk_i,
    input  logic             rst_i,
    aes_cipher_ctrl_if.slave ctrl
);
    // Datapath mux encodings
    localparam logic [1:0] STATE_INIT        = 2'd0;
    localparam logic [1:0] STATE_ROUND       = 2'd1;
    localparam logic [1:0] STATE_CLEAR       = 2'd2;
    localparam logic [1:0] ADD_RK_INIT       = 2'd0;
    localparam logic [1:0] ADD_RK_ROUND      = 2'd1;
    localparam logic [1:0] ADD_RK_FINAL      = 2'd2;
    localparam logic [1:0] KEY_FULL_ENC_INIT = 2'd0;
    localparam logic [1:0] KEY_FULL_DEC_INIT = 2'd1;
    localparam logic [1:0] KEY_FULL_ROUND    = 2'd2;
    localparam logic [1:0] KEY_FULL_CLEAR    = 2'd3;
    localparam logic       KEY_DEC_EXPAND    = 1'b0;
    localparam logic       KEY_DEC_CLEAR     = 1'b1;
    localparam logic       CIPH_FWD          = 1'b0;
    localparam logic       CIPH_INV          = 1'b1;
    localparam logic [2:0] AES_128           = 3'b001;
    localparam logic [2:0] AES_192           = 3'b010;
    localparam logic [2:0] AES_256           = 3'b100;

    // FSM states
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_ROUND  = 3'd2;
    localparam logic [2:0] S_FINISH = 3'd3;
    localparam logic [2:0] S_CLEAR  = 3'd4;

    logic [2:0] r_state;
    logic       r_dec_key_gen;
    logic       r_key_clear;
    logic       r_data_out_clear;
    logic       r_op;
    logic [2:0] r_key_len;
    logic [3:0] r_round;

    logic [2:0] w_state_d;
    logic       w_dec_key_gen_d;
    logic       w_key_clear_d;
    logic       w_data_out_clear_d;
    logic       w_op_d;
    logic [2:0] w_key_len_d;
    logic [3:0] w_round_d;

    logic [2:0] w_key_len_in;
    logic [3:0] w_last_round;
    logic       w_accept_start;
    logic       w_accept_clear;
    logic       w_dec_init;

    // Normalise the requested key length; anything not one-hot runs as AES-128
    always_comb begin
        case (ctrl.key_len_i)
            AES_192: w_key_len_in = AES_192;
            AES_256: w_key_len_in = AES_256;
            default: w_key_len_in = AES_128;
        endcase
    end

    // Index of the last full round (Nr-1) for the latched key length
    always_comb begin
        case (r_key_len)
            AES_192: w_last_round = 4'd11;
            AES_256: w_last_round = 4'd13;
            default: w_last_round = 4'd9;
        endcase
    end

    assign w_accept_start = (r_state == S_IDLE) & ctrl.in_valid_i & ctrl.start_i;
    assign w_accept_clear = (r_state == S_IDLE) & ctrl.in_valid_i & ~ctrl.start_i &
                            (ctrl.key_clear_i | ctrl.data_out_clear_i);

    // Inverse cipher without key generation starts from the stored decryption key
    assign w_dec_init = (r_op == CIPH_INV) & ~r_dec_key_gen;

    // Next-state and latched-request logic
    always_comb begin
        w_state_d          = r_state;
        w_dec_key_gen_d    = r_dec_key_gen;
        w_key_clear_d      = r_key_clear;
        w_data_out_clear_d = r_data_out_clear;
        w_op_d             = r_op;
        w_key_len_d        = r_key_len;
        w_round_d          = r_round;

        case (r_state)
            S_IDLE: begin
                if (w_accept_start) begin
                    w_op_d             = ctrl.op_i;
                    w_key_len_d        = w_key_len_in;
                    w_dec_key_gen_d    = ctrl.dec_key_gen_i;
                    w_key_clear_d      = 1'b0;
                    w_data_out_clear_d = 1'b0;
                    w_round_d          = 4'd0;
                    w_state_d          = S_INIT;
                end else if (w_accept_clear) begin
                    w_key_clear_d      = ctrl.key_clear_i;
                    w_data_out_clear_d = ctrl.data_out_clear_i;
                    w_state_d          = S_CLEAR;
                end
                // A request with no qualifier is accepted and dropped.
            end

            S_INIT: begin
                w_round_d = 4'd1;
                w_state_d = S_ROUND;
            end

            S_ROUND: begin
                w_round_d = r_round + 4'd1;
                if (r_round == w_last_round) begin
                    w_state_d = S_FINISH;
                end
            end

            S_FINISH, S_CLEAR: begin
                if (ctrl.out_ready_i) begin
                    w_dec_key_gen_d    = 1'b0;
                    w_key_clear_d      = 1'b0;
                    w_data_out_clear_d = 1'b0;
                    w_state_d          = S_IDLE;
                end
            end

            default: w_state_d = S_IDLE;
        endcase
    end

    // State and request registers; reset aborts straight to IDLE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state          <= S_IDLE;
            r_dec_key_gen    <= 1'b0;
            r_key_clear      <= 1'b0;
            r_data_out_clear <= 1'b0;
            r_op             <= CIPH_FWD;
            r_key_len        <= 3'b000;
            r_round          <= 4'd0;
        end else begin
            r_state          <= w_state_d;
            r_dec_key_gen    <= w_dec_key_gen_d;
            r_key_clear      <= w_key_clear_d;
            r_data_out_clear <= w_data_out_clear_d;
            r_op             <= w_op_d;
            r_key_len        <= w_key_len_d;
            r_round          <= w_round_d;
        end
    end

    // Handshake and datapath control decoded from the current state
    always_comb begin
        ctrl.in_ready_o         = 1'b0;
        ctrl.out_valid_o        = 1'b0;
        ctrl.state_sel_o        = STATE_INIT;
        ctrl.state_we_o         = 1'b0;
        ctrl.add_rk_sel_o       = ADD_RK_INIT;
        ctrl.key_full_sel_o     = KEY_FULL_ENC_INIT;
        ctrl.key_full_we_o      = 1'b0;
        ctrl.key_dec_sel_o      = KEY_DEC_EXPAND;
        ctrl.key_dec_we_o       = 1'b0;
        ctrl.key_expand_step_o  = 1'b0;
        ctrl.key_expand_clear_o = 1'b0;

        case (r_state)
            S_IDLE: begin
                ctrl.in_ready_o         = 1'b1;
                // Restart rcon together with the accept so INIT sees round 0
                ctrl.key_expand_clear_o = w_accept_start;
            end

            S_INIT: begin
                ctrl.state_sel_o    = STATE_INIT;
                ctrl.add_rk_sel_o   = ADD_RK_INIT;
                ctrl.state_we_o     = ~r_dec_key_gen;
                ctrl.key_full_sel_o = w_dec_init ? KEY_FULL_DEC_INIT : KEY_FULL_ENC_INIT;
                ctrl.key_full_we_o  = 1'b1;
            end

            S_ROUND: begin
                ctrl.state_sel_o       = STATE_ROUND;
                ctrl.add_rk_sel_o      = ADD_RK_ROUND;
                ctrl.state_we_o        = ~r_dec_key_gen;
                ctrl.key_full_sel_o    = KEY_FULL_ROUND;
                ctrl.key_full_we_o     = 1'b1;
                ctrl.key_expand_step_o = 1'b1;
            end

            S_FINISH: begin
                ctrl.out_valid_o   = 1'b1;
                ctrl.state_sel_o   = STATE_ROUND;
                ctrl.add_rk_sel_o  = ADD_RK_FINAL;
                // Final round result lands only in the handshake cycle
                ctrl.state_we_o    = ctrl.out_ready_i & ~r_dec_key_gen;
                ctrl.key_dec_sel_o = KEY_DEC_EXPAND;
                ctrl.key_dec_we_o  = ctrl.out_ready_i & r_dec_key_gen;
            end

            S_CLEAR: begin
                ctrl.out_valid_o = 1'b1;
                // Clear writes repeat every cycle until the handshake; harmless
                if (r_key_clear) begin
                    ctrl.key_full_sel_o     = KEY_FULL_CLEAR;
                    ctrl.key_full_we_o      = 1'b1;
                    ctrl.key_dec_sel_o      = KEY_DEC_CLEAR;
                    ctrl.key_dec_we_o       = 1'b1;
                    ctrl.key_expand_clear_o = 1'b1;
                end
                if (r_data_out_clear) begin
                    ctrl.state_sel_o = STATE_CLEAR;
                    ctrl.state_we_o  = 1'b1;
                end
            end

            default: ;
        endcase
    end

    assign ctrl.dec_key_gen_o    = r_dec_key_gen;
    assign ctrl.key_clear_o      = r_key_clear;
    assign ctrl.data_out_clear_o = r_data_out_clear;
    assign ctrl.op_o             = r_op;
    assign ctrl.key_len_o        = r_key_len;
    assign ctrl.round_o          = r_round;
endmodule

// File: doc/aes_cipher_ctrl.md
# aes_cipher_ctrl

Round-sequencing controller inside the AES cipher core. It is the responder on the `cipher_in_valid/ready` and `cipher_out_valid/ready` handshakes driven by the top-level AES control FSM. It accepts start, decryption-key-generation and clear requests, then sequences the initial, middle and final rounds. While it does so it drives the mux selects and write enables of the state, full-key and decryption-key registers. Completion is signalled back through the output handshake.

## Interface
- No parameters. Encodings are the package localparams: `STATE_INIT/ROUND/CLEAR`, `ADD_RK_INIT/ROUND/FINAL`, `KEY_FULL_ENC_INIT/DEC_INIT/ROUND/CLEAR`, `KEY_DEC_EXPAND/CLEAR`, `CIPH_FWD/INV`, `AES_128/192/256`.
- `clk_i` in 1: clock. One clock domain.
- `rst_i` in 1: reset, asynchronous, active-high.
- `in_valid_i` in 1: request valid.
- `in_ready_o` out 1: request accepted.
- `out_valid_o` out 1: operation done.
- `out_ready_i` in 1: completion consumed.
- `start_i`, `dec_key_gen_i`, `key_clear_i`, `data_out_clear_i` in 1 each: request qualifiers, sampled on accept.
- `op_i` in 1: `CIPH_FWD`/`CIPH_INV`.
- `key_len_i` in 3: one-hot key length.
- `dec_key_gen_o`, `key_clear_o`, `data_out_clear_o` out 1 each: latched request flags.
- `op_o` out 1: latched operation.
- `key_len_o` out 3: latched key length.
- `round_o` out 4: current round index.
- `state_sel_o` out 2, `state_we_o` out 1: state register control.
- `add_rk_sel_o` out 2: AddRoundKey input select.
- `key_full_sel_o` out 2, `key_full_we_o` out 1: full-key register control.
- `key_dec_sel_o` out 1, `key_dec_we_o` out 1: decryption-key register control.
- `key_expand_step_o` out 1: advance the key-expansion unit by one round.
- `key_expand_clear_o` out 1: reset the key-expansion unit (rcon).

## Operation
- FSM states: IDLE, INIT, ROUND, FINISH, CLEAR. The latched flags, op, key length and round are registers.
- Nr = 10/12/14 for `AES_128`/`AES_192`/`AES_256`. Any non-one-hot `key_len_i` is latched as `AES_128`.
- **IDLE**
  - `in_ready_o`=1.
  - On `in_valid_i & start_i`:
    - latch `op_i`, key length and `dec_key_gen_i`;
    - clear `key_clear_q` and `data_out_clear_q`;
    - `round_q`=0, `key_expand_clear_o`=1;
    - next state INIT.
  - Else on `in_valid_i & (key_clear_i | data_out_clear_i)`: latch both clear flags, next state CLEAR.
  - Else, if `in_valid_i`=1 with no qualifier: the request is accepted and dropped; stay in IDLE.
  - Start wins over clear when both are set; clear qualifiers are not latched in that case.
- **INIT** (one cycle)
  - `state_sel_o`=`STATE_INIT`, `add_rk_sel_o`=`ADD_RK_INIT`.
  - `state_we_o` = ~`dec_key_gen_q`.
  - `key_full_sel_o` = `KEY_FULL_DEC_INIT` if (`op_q`==`CIPH_INV` & ~`dec_key_gen_q`), else `KEY_FULL_ENC_INIT`.
  - `key_full_we_o`=1.
  - `round_q`←1, next state ROUND.
- **ROUND** (rounds 1..Nr-1)
  - `state_sel_o`=`STATE_ROUND`, `add_rk_sel_o`=`ADD_RK_ROUND`.
  - `state_we_o` = ~`dec_key_gen_q`.
  - `key_full_sel_o`=`KEY_FULL_ROUND`, `key_full_we_o`=1, `key_expand_step_o`=1.
  - If `round_q`==Nr-1: `round_q`←Nr and next state FINISH. Else `round_q`+1.
- **FINISH**
  - `out_valid_o`=1, `add_rk_sel_o`=`ADD_RK_FINAL`, `state_sel_o`=`STATE_ROUND`.
  - `state_we_o` = `out_ready_i` & ~`dec_key_gen_q`, so the final-round result is written in the handshake cycle only.
  - `key_dec_sel_o`=`KEY_DEC_EXPAND`, `key_dec_we_o` = `out_ready_i` & `dec_key_gen_q`.
  - On `out_ready_i`: next state IDLE, and all latched flags clear.
- **CLEAR**
  - `out_valid_o`=1. The clear writes are asserted every cycle in this state; they are idempotent.
  - If `key_clear_q`:
    - `key_full_sel_o`=`KEY_FULL_CLEAR`, `key_full_we_o`=1;
    - `key_dec_sel_o`=`KEY_DEC_CLEAR`, `key_dec_we_o`=1;
    - `key_expand_clear_o`=1.
  - If `data_out_clear_q`: `state_sel_o`=`STATE_CLEAR`, `state_we_o`=1.
  - On `out_ready_i`: next state IDLE, flags clear.
- Output defaults: all selects 0 and all enables 0 unless a rule above sets them.
- The `*_o` flag, op, key-length and round outputs are direct register outputs. They hold their values through FINISH and CLEAR so the top-level FSM can inspect them during the output handshake.

## Timing
- Reset (async, active-high):
  - FSM in IDLE, all registers 0, so `in_ready_o`=1 combinationally;
  - `out_valid_o`=0, every other output 0;
  - `key_len_o`=0 until the first start.
- Reset mid-operation aborts immediately to IDLE. No clear is performed.
- Accepting a start request in cycle T0 gives:
  - INIT in T0+1;
  - ROUND in T0+2 .. T0+Nr;
  - `out_valid_o` first high in T0+Nr+1 (11 / 13 / 15 cycles after T0).
- Accepting a clear request in T0 gives `out_valid_o` in T0+1.
- `out_valid_o` stays high until `out_ready_i`. `out_ready_i` outside FINISH/CLEAR has no effect.
- `in_ready_o` is high only in IDLE. Back-to-back: a new request can be accepted in the cycle after the output handshake.
- `round_o` matches the round whose signals are driven in the same cycle.

## Test plan
- **AES-128 encryption:** start with `op_i`=`CIPH_FWD`, `key_len_i`=001 accepted at T0.
  - T0+1: `state_we_o`=1, `key_full_sel_o`=`KEY_FULL_ENC_INIT`.
  - T0+2..T0+10: 9 `key_expand_step_o` pulses, `round_o` 1..9.
  - T0+11: `out_valid_o`=1, `round_o`=10.
  - `out_ready_i` held low 3 cycles: no `state_we_o` until `out_ready_i`=1; back to IDLE the cycle after.
- **AES-256 decryption with `dec_key_gen_i`=1:**
  - `state_we_o` never asserted;
  - `out_valid_o` at T0+15;
  - `key_dec_we_o`=1 exactly in the handshake cycle;
  - `dec_key_gen_o`=1 until then.
- **AES-192 decryption without key generation:** `key_full_sel_o`=`KEY_FULL_DEC_INIT` in INIT; 11 ROUND cycles; `out_valid_o` at T0+13.
- **Combined clear:** `key_clear_i`=1 and `data_out_clear_i`=1, `start_i`=0.
  - T0+1: `key_full_we_o`, `key_dec_we_o`, `state_we_o` all 1; `state_sel_o`=`STATE_CLEAR`; `out_valid_o`=1.
  - Flags clear after the handshake.
- **Simultaneous qualifiers:** `start_i`=1 and `key_clear_i`=1 together start a cipher with `key_clear_o`=0. `in_valid_i` with no qualifier keeps the FSM in IDLE and all write enables 0.
- **Reset and key length:**
  - `rst_i` pulsed at T0+5 of an AES-128 run: FSM in IDLE with all outputs 0 and `in_ready_o`=1 immediately, with no clock edge needed.
  - `key_len_i`=011 then gives `key_len_o`=001 and an 11-cycle latency.
